// File: rtl/ddr3_cmd_responder_if.sv
// Memory-side DDR3 pin bundle between the controller (master) and the
// single-data-rate device responder (slave).
interface ddr3_cmd_responder_if #(
   parameter int ADDRESS_BITWIDTH      = 15,
   parameter int BANK_ADDRESS_BITWIDTH = 3,
   parameter int DQ_BITWIDTH           = 8
);
   logic                                   ck_en;
   logic                                   cs_n;
   logic                                   ras_n;
   logic                                   cas_n;
   logic                                   we_n;
   logic [BANK_ADDRESS_BITWIDTH-1:0]       bank_address;
   logic [ADDRESS_BITWIDTH-1:0]            address;
   logic [DQ_BITWIDTH-1:0]                 dq_in;
   logic [DQ_BITWIDTH-1:0]                 dq_out;
   logic                                   dq_oe;
   logic                                   dqs_out;
   logic [(1<<BANK_ADDRESS_BITWIDTH)-1:0]  bank_open;
   logic                                   cmd_error;
   logic [7:0]                             error_count;
   logic                                   busy;

   modport master (
      output ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dq_in,
      input  dq_out, dq_oe, dqs_out, bank_open, cmd_error, error_count, busy
   );

   modport slave (
      input  ck_en, cs_n, ras_n, cas_n, we_n, bank_address, address, dq_in,
      output dq_out, dq_oe, dqs_out, bank_open, cmd_error, error_count, busy
   );
endinterface

// File: rtl/ddr3_cmd_responder.sv
// Single-data-rate DDR3 device stand-in: decodes commands, tracks open banks,
// stores one BL8 burst at a time in a small RAM and replays it on reads with
// fixed CL/CWL. Protocol violations pulse cmd_error and bump a saturating count.
module ddr3_cmd_responder #(
   parameter int ADDRESS_BITWIDTH      = 15,
   parameter int BANK_ADDRESS_BITWIDTH = 3,
   parameter int DQ_BITWIDTH           = 8,
   parameter int MEM_ADDR_BITS         = 6,
   parameter int CL                    = 5,
   parameter int CWL                   = 5,
   parameter int BURST_LEN             = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reset_n,
   ddr3_cmd_responder_if.slave   bus
);
   localparam int NUM_BANKS = 1 << BANK_ADDRESS_BITWIDTH;
   localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;
   localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

   // {ras_n,cas_n,we_n} with cs_n already known low
   localparam logic [2:0] CMD_MRS  = 3'b000;
   localparam logic [2:0] CMD_REF  = 3'b001;
   localparam logic [2:0] CMD_PRE  = 3'b010;
   localparam logic [2:0] CMD_ACT  = 3'b011;
   localparam logic [2:0] CMD_WR   = 3'b100;
   localparam logic [2:0] CMD_RD   = 3'b101;
   localparam logic [2:0] CMD_ZQCL = 3'b110;

   typedef enum logic [2:0] {IDLE, W_WAIT, W_BURST, R_WAIT, R_BURST} state_e;

   state_e                                       state_q, state_d;
   logic [3:0]                                   cnt_q, cnt_d;
   logic [2:0]                                   beat_q, beat_d;
   logic [MEM_ADDR_BITS-1:0]                     base_q, base_d;
   logic [NUM_BANKS-1:0]                         bank_open_q, bank_open_d;
   logic [NUM_BANKS-1:0][ADDRESS_BITWIDTH-1:0]   row_q, row_d;
   logic                                         cmd_error_q, cmd_error_d;
   logic [7:0]                                   error_count_q, error_count_d;

   logic [DQ_BITWIDTH-1:0]   ram_q [MEM_WORDS];
   logic [MEM_ADDR_BITS-1:0] ram_idx;
   logic                     rst, busy, err, cmd_valid, bank_is_open;
   logic [2:0]               cmd;
   logic                     unused_row;

   // The DDR reset pin behaves exactly like the core reset.
   assign rst          = reset | ~reset_n;
   assign busy         = (state_q != IDLE);
   assign cmd_valid    = bus.ck_en & ~bus.cs_n;
   assign cmd          = {bus.ras_n, bus.cas_n, bus.we_n};
   assign bank_is_open = bank_open_q[bus.bank_address];
   // Beat address wraps inside the 8-aligned block of the start column.
   assign ram_idx      = {base_q[MEM_ADDR_BITS-1:3], 3'(base_q[2:0] + beat_q)};
   // Open rows are recorded for visibility only; nothing downstream needs them.
   assign unused_row   = ^row_q;

   // Burst sequencing plus command decode and protocol checking.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      beat_d      = beat_q;
      base_d      = base_q;
      bank_open_d = bank_open_q;
      row_d       = row_q;
      err         = 1'b0;

      case (state_q)
         W_WAIT, R_WAIT: begin
            if (cnt_q == 4'd0) state_d = (state_q == W_WAIT) ? W_BURST : R_BURST;
            else               cnt_d   = cnt_q - 4'd1;
         end
         W_BURST, R_BURST: begin
            beat_d = beat_q + 3'd1;
            if (beat_q == LAST_BEAT) state_d = IDLE;
         end
         default: ;
      endcase

      if (cmd_valid) begin
         case (cmd)
            CMD_MRS, CMD_ZQCL: err = busy;
            CMD_REF:           err = |bank_open_q;
            CMD_PRE: begin
               if (bus.address[10]) bank_open_d = '0;
               else                 bank_open_d[bus.bank_address] = 1'b0;
            end
            CMD_ACT: begin
               if (bank_is_open) err = 1'b1;
               else begin
                  bank_open_d[bus.bank_address] = 1'b1;
                  row_d[bus.bank_address]       = bus.address;
               end
            end
            CMD_WR, CMD_RD: begin
               if (!bank_is_open || busy) err = 1'b1;
               else begin
                  // Accepted only from IDLE, so this never fights the sequencer above.
                  base_d = MEM_ADDR_BITS'({bus.bank_address, bus.address});
                  beat_d = 3'd0;
                  if (cmd == CMD_WR) begin
                     // Wait state spends CWL-1 cycles; CWL=1 starts the burst at once.
                     if (CWL == 1) state_d = W_BURST;
                     else begin
                        state_d = W_WAIT;
                        cnt_d   = 4'(CWL - 2);
                     end
                  end else begin
                     state_d = R_WAIT;
                     cnt_d   = 4'(CL - 2);
                  end
               end
            end
            default: ;
         endcase
      end

      cmd_error_d   = err;
      error_count_d = (err && error_count_q != 8'hFF) ? error_count_q + 8'd1 : error_count_q;
   end

   // State registers; reset aborts any burst and closes every bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         beat_q        <= '0;
         base_q        <= '0;
         bank_open_q   <= '0;
         row_q         <= '0;
         cmd_error_q   <= 1'b0;
         error_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         beat_q        <= beat_d;
         base_q        <= base_d;
         bank_open_q   <= bank_open_d;
         row_q         <= row_d;
         cmd_error_q   <= cmd_error_d;
         error_count_q <= error_count_d;
      end
   end

   // Burst storage; contents survive reset, a reset beat is simply not written.
   always_ff @(posedge clk) begin
      if (!rst && state_q == W_BURST) ram_q[ram_idx] <= bus.dq_in;
   end

   assign bus.dq_oe       = (state_q == R_BURST);
   assign bus.dq_out      = bus.dq_oe ? ram_q[ram_idx] : '0;
   assign bus.dqs_out     = bus.dq_oe & ~beat_q[0];
   assign bus.bank_open   = bank_open_q;
   assign bus.cmd_error   = cmd_error_q;
   assign bus.error_count = error_count_q;
   assign bus.busy        = busy;
endmodule
